// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key map, debounce states, scan results.
package keypad_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_res_t;

  // Pmod keypad legend, row 0 at top, column 0 at left.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
  parameter int          WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with full-scan debounce and hex key code output.
//  state        | meaning
//  IDLE         | no key accepted, waiting for a single hit
//  PRESS_PEND   | same single key seen cnt scans in a row
//  HELD         | key accepted, key_down high
//  RELEASE_PEND | empty scans counted toward release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_TGT   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [3:0]    row_s;
  logic [TW-1:0] tick;
  logic [1:0]    phase;
  logic [15:0]   hits;       // bit c*4+r set when row r was low during column c
  logic          scan_done;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    candidate;
  logic [1:0]    n_hits;
  logic [3:0]    hit_code;
  scan_res_t     scan_res;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign col = ~(4'b0001 << phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      phase     <= '0;
      hits      <= '0;
      scan_done <= 1'b0;
    end else if (tick == TICK_LAST) begin
      tick                    <= '0;
      phase                   <= phase + 2'd1;
      hits[{phase, 2'b00} +: 4] <= ~row_s;
      scan_done               <= (phase == 2'd3);
    end else begin
      tick      <= tick + TW'(1);
      scan_done <= 1'b0;
    end
  end

  always_comb begin
    n_hits   = 2'd0;
    hit_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
        hit_code = key_map(2'(i), 2'(i >> 2));
      end
    end
    if (n_hits == 2'd0)      scan_res = SCAN_NONE;
    else if (n_hits == 2'd1) scan_res = SCAN_SINGLE;
    else                     scan_res = SCAN_MULTI;
    cnt_inc = (cnt == CNT_TGT) ? cnt : cnt + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      candidate <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_res == SCAN_SINGLE) begin
              candidate <= hit_code;
              if (DEBOUNCE_SCANS == 1) begin
                key_code  <= hit_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
                state     <= ST_HELD;
              end else begin
                cnt   <= CNT_ONE;
                state <= ST_PRESS_PEND;
              end
            end
          end
          ST_PRESS_PEND: begin
            if (scan_res == SCAN_SINGLE) begin
              if (hit_code == candidate) begin
                if (cnt_inc >= CNT_TGT) begin
                  key_code  <= candidate;
                  key_valid <= 1'b1;
                  key_down  <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_HELD;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                candidate <= hit_code;
                cnt       <= CNT_ONE;
              end
            end else begin
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (scan_res == SCAN_NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_down <= 1'b0;
                cnt      <= '0;
                state    <= ST_IDLE;
              end else begin
                cnt   <= CNT_ONE;
                state <= ST_RELEASE_PEND;
              end
            end
          end
          default: begin
            if (scan_res == SCAN_NONE) begin
              if (cnt_inc >= CNT_TGT) begin
                key_down <= 1'b0;
                cnt      <= '0;
                state    <= ST_IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              state <= ST_HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad pin model, scan-level reference model and strobe scoreboard.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_down;
  logic [15:0] keys = '0;  // bit r*4+c = key at row r, column c pressed

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  // Reference: a key is accepted after DB identical single-key scans while up,
  // released after DB empty scans while down.
  bit         m_down = 1'b0;
  logic [3:0] m_code = 4'h0;
  int         run_len = 0;
  int         prev_kind = -2;

  function automatic logic [15:0] k1(input int idx);
    logic [15:0] m;
    m = 16'h0001 << idx;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_down = 1'b0;
    m_code = 4'h0;
    run_len = 0;
    prev_kind = -2;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int kind;
    int n;
    n = $countones(k);
    kind = -1;
    if (n > 1) kind = 16;
    else if (n == 1)
      for (int i = 0; i < 16; i++) if (k[i]) kind = int'(key_tab[i]);
    if (kind == prev_kind) run_len++;
    else run_len = 1;
    prev_kind = kind;
    if (!m_down && kind >= 0 && kind < 16 && run_len >= DB) begin
      m_down = 1'b1;
      m_code = 4'(kind);
      exp_q.push_back(4'(kind));
    end else if (m_down && kind == -1 && run_len >= DB) begin
      m_down = 1'b0;
    end
  endtask

  // Called on a scan-start negedge; returns on the next scan-start negedge.
  task automatic run_scan(input logic [15:0] k);
    keys = k;
    @(negedge clk);
    check("key_down", 32'(key_down), 32'(m_down));
    check("key_code_held", 32'(key_code), 32'(m_code));
    repeat (ST*4 - 1) @(negedge clk);
    model_scan(k);
  endtask

  task automatic run_scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k);
  endtask

  // Monitor: pops the scoreboard on every strobe and checks strobe invariants.
  logic       prev_valid = 1'b0;
  logic [3:0] last_code  = 4'h0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        if (prev_valid) begin
          n_fail++;
          $display("FAIL valid_twice: key_valid high two cycles in a row (t=%0t)", $time);
        end
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got code %0h, expected no strobe (t=%0t)", key_code, $time);
        end else begin
          check("strobe_code", 32'(key_code), 32'(exp_q.pop_front()));
        end
      end else if (key_code !== last_code) begin
        n_fail++;
        $display("FAIL code_no_strobe: key_code %0h, expected %0h (t=%0t)", key_code, last_code, $time);
      end
    end
    prev_valid = key_valid;
    last_code  = key_code;
  end

  initial begin
    logic [3:0]  ec;
    logic [15:0] k;
    int a, b, sel, len;

    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0E);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ec = ~(4'b0001 << ((i / ST) % 4));
      check("col_seq", 32'(col), 32'(ec));
      @(negedge clk);
    end
    repeat (12) @(negedge clk);

    run_scans(k1(5), 12);                 // '5' held
    run_scans('0, 3);                     // release
    run_scan(k1(15));                     // 'D' bounce
    run_scans(k1(12), 3);                 // '0'
    run_scans('0, 2);
    run_scans(k1(13), 2);                 // 'F'
    run_scans('0, 2);
    run_scans(k1(0) | k1(10), 3);         // '1'+'9'
    run_scans(k1(10), 3);                 // '9' alone
    run_scans('0, 2);

    run_scan(k1(8));                      // '7' into PRESS_PEND
    keys = k1(8);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_col", 32'(col), 32'h0E);
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_down", 32'(key_down), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_scans(k1(8), 3);
    run_scans('0, 2);

    for (int seg = 0; seg < 30; seg++) begin
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (sel < 6)      k = k1(a);
      else if (sel < 8) k = '0;
      else              k = k1(a) | k1(b);
      len = $urandom_range(1, 3);
      run_scans(k, len);
    end
    run_scans('0, 3);
    repeat (4) @(negedge clk);
    check("pending_strobes", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
